mem2axi: RTL and testbench
==========================

// Module: mem2axi
// PURPOSE
//  Memory-request-to-AXI master bridge: converts a simple req/gnt/rvalid memory port into
//  single-beat AXI4 read/write transactions. Used where a core-side SRAM-style initiator must
//  reach memory behind an AXI interconnect. One outstanding transaction; no bursts.
// PARAMETERS
//  AXI_ID_WIDTH    10  width of AXI ID fields
//  AXI_ADDR_WIDTH  64  address width (memory port and AXI)
//  AXI_DATA_WIDTH  64  data width; NB = AXI_DATA_WIDTH/8, LOG_NR_BYTES = $clog2(NB)
//  AXI_USER_WIDTH  10  width of AXI user fields (driven '0)
//  TXN_ID          0   constant ID driven on aw_id/ar_id
// PORTS
//  clk_i    in   1               clock
//  rst_i    in   1               synchronous reset, active-high
//  req_i    in   1               memory request valid
//  gnt_o    out  1               request accepted (same cycle as req_i)
//  we_i     in   1               1 = write, 0 = read
//  addr_i   in   AXI_ADDR_WIDTH  byte address
//  be_i     in   NB              byte enables (write strobes)
//  wdata_i  in   AXI_DATA_WIDTH  write data
//  rvalid_o out  1               one-cycle response pulse (read data or write ack)
//  rdata_o  out  AXI_DATA_WIDTH  read data, valid with rvalid_o (reads only)
//  err_o    out  1               response error, valid with rvalid_o
//  master   --   AXI_BUS.Master  AXI4 master port
// BEHAVIOUR
//  Reset: state IDLE; gnt_o, rvalid_o, err_o, all AXI valids/readies = 0; rdata_o = '0.
//  Reset mid-transaction: return to IDLE next cycle and drop all valids; outstanding transaction discarded.
//  States: IDLE, SEND_AW_W, SEND_AR, WAIT_B, WAIT_R, RESP.
//  IDLE: gnt_o = req_i (combinational). On req_i, latch addr_i with low LOG_NR_BYTES bits cleared,
//    be_i, wdata_i, we_i. Go to SEND_AW_W if we_i, else SEND_AR. req_i is ignored in all other states.
//  SEND_AW_W: aw_valid = ~aw_done, w_valid = ~w_done. aw_done/w_done are set on their own handshakes.
//    Either order or the same cycle is legal. When both are done (the flags, or a handshake in this
//    cycle), go to WAIT_B and clear the flags.
//  SEND_AR: ar_valid = 1; on ar_ready, go to WAIT_R.
//  WAIT_B: b_ready = 1; on b_valid, err_o_q = b_resp[1]; go to RESP.
//  WAIT_R: r_ready = 1; on r_valid, rdata_q = r_data and err_o_q = r_resp[1] | ~r_last; go to RESP.
//  RESP: rvalid_o = 1 for exactly one cycle; return to IDLE. gnt_o = 0 in RESP.
//  AX fields: len = 0, size = LOG_NR_BYTES, burst = INCR(2'b01), id = TXN_ID, cache/prot/qos/region/lock/
//    user = '0. W: data = latched wdata, strb = latched be, last = 1.
//  All AXI valid and payload outputs come from registers, never from inputs combinationally.
//  Payload is held stable while valid is high and ready is low.
//  Response ID is not checked (single outstanding). b_valid/r_valid outside WAIT_B/WAIT_R are not accepted.
//  Min latency (zero-wait slave): gnt in cycle 0, AXI valid in cycle 1, resp accepted in cycle 2,
//    rvalid_o in cycle 3. The next gnt_o is possible in cycle 4.
//  rdata_o holds its last read value until the next read completes; rdata_o is don't-care on write responses.
// TESTING
//  1 Read, zero-wait slave: req addr 0x1007 -> ar_addr 0x1000, len 0, size 3; rvalid_o in cycle 3,
//    rdata_o = slave data 0xDEADBEEF_CAFEF00D, err_o 0.
//  2 Write, be 0x0F, data 0x11223344_55667788: aw and w accepted in the same cycle -> w_strb 0x0F,
//    w_last 1; b_resp OKAY -> rvalid_o pulse, err_o 0.
//  3 Write, w_ready 3 cycles before aw_ready -> w_valid drops after its handshake; aw_valid held with
//    stable payload; single rvalid_o.
//  4 Read with r_resp SLVERR (2'b10), and separately a write with b_resp DECERR -> rvalid_o with err_o 1 each time.
//  5 Back-to-back: req_i held high for 3 requests -> gnt_o only in IDLE cycles; exactly 3 rvalid_o
//    pulses, in order.
//  6 rst_i asserted while in WAIT_R -> next cycle IDLE with all valids/readies 0; a later r_valid is
//    ignored; a new read completes normally.

Source files
------------

// File: rtl/mem2axi.sv
// Bridge from a req/gnt/rvalid memory port to single-beat AXI4 read/write transactions.
// One transaction in flight at a time; every AXI valid and payload is driven from registers.
module mem2axi #(
    parameter int unsigned                    AXI_ID_WIDTH   = 10,
    parameter int unsigned                    AXI_ADDR_WIDTH = 64,
    parameter int unsigned                    AXI_DATA_WIDTH = 64,
    parameter int unsigned                    AXI_USER_WIDTH = 10,
    parameter logic [AXI_ID_WIDTH-1:0]        TXN_ID         = '0
) (
    input  logic                              clk_i,
    input  logic                              rst_i,

    // memory-side port
    input  logic                              req_i,
    output logic                              gnt_o,
    input  logic                              we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]         addr_i,
    input  logic [AXI_DATA_WIDTH/8-1:0]       be_i,
    input  logic [AXI_DATA_WIDTH-1:0]         wdata_i,
    output logic                              rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]         rdata_o,
    output logic                              err_o,

    // AXI write address channel
    output logic [AXI_ID_WIDTH-1:0]           aw_id,
    output logic [AXI_ADDR_WIDTH-1:0]         aw_addr,
    output logic [7:0]                        aw_len,
    output logic [2:0]                        aw_size,
    output logic [1:0]                        aw_burst,
    output logic                              aw_lock,
    output logic [3:0]                        aw_cache,
    output logic [2:0]                        aw_prot,
    output logic [3:0]                        aw_qos,
    output logic [3:0]                        aw_region,
    output logic [AXI_USER_WIDTH-1:0]         aw_user,
    output logic                              aw_valid,
    input  logic                              aw_ready,

    // AXI write data channel
    output logic [AXI_DATA_WIDTH-1:0]         w_data,
    output logic [AXI_DATA_WIDTH/8-1:0]       w_strb,
    output logic                              w_last,
    output logic [AXI_USER_WIDTH-1:0]         w_user,
    output logic                              w_valid,
    input  logic                              w_ready,

    // AXI write response channel
    input  logic [AXI_ID_WIDTH-1:0]           b_id,
    input  logic [1:0]                        b_resp,
    input  logic [AXI_USER_WIDTH-1:0]         b_user,
    input  logic                              b_valid,
    output logic                              b_ready,

    // AXI read address channel
    output logic [AXI_ID_WIDTH-1:0]           ar_id,
    output logic [AXI_ADDR_WIDTH-1:0]         ar_addr,
    output logic [7:0]                        ar_len,
    output logic [2:0]                        ar_size,
    output logic [1:0]                        ar_burst,
    output logic                              ar_lock,
    output logic [3:0]                        ar_cache,
    output logic [2:0]                        ar_prot,
    output logic [3:0]                        ar_qos,
    output logic [3:0]                        ar_region,
    output logic [AXI_USER_WIDTH-1:0]         ar_user,
    output logic                              ar_valid,
    input  logic                              ar_ready,

    // AXI read data channel
    input  logic [AXI_ID_WIDTH-1:0]           r_id,
    input  logic [AXI_DATA_WIDTH-1:0]         r_data,
    input  logic [1:0]                        r_resp,
    input  logic                              r_last,
    input  logic [AXI_USER_WIDTH-1:0]         r_user,
    input  logic                              r_valid,
    output logic                              r_ready
);

    localparam int unsigned NB           = AXI_DATA_WIDTH / 8;
    localparam int unsigned LOG_NR_BYTES = $clog2(NB);
    localparam logic [2:0]  AX_SIZE      = 3'(LOG_NR_BYTES);
    localparam logic [1:0]  BURST_INCR   = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        SEND_AW_W,
        SEND_AR,
        WAIT_B,
        WAIT_R,
        RESP
    } state_e;

    state_e                     state_q, state_d;
    logic                       aw_done_q, aw_done_d;
    logic                       w_done_q, w_done_d;
    logic                       aw_fin, w_fin;
    logic                       err_q;
    logic [AXI_DATA_WIDTH-1:0]  rdata_q;
    logic [AXI_ADDR_WIDTH-1:0]  addr_q;
    logic [NB-1:0]              be_q;
    logic [AXI_DATA_WIDTH-1:0]  wdata_q;

    // Response IDs are irrelevant with a single transaction in flight.
    logic unused_inputs;
    assign unused_inputs = ^{b_id, b_user, r_id, r_user, addr_i[LOG_NR_BYTES-1:0]};

    // A handshake this cycle counts as done, so AW and W may finish in either order or together.
    assign aw_fin = aw_done_q | aw_ready;
    assign w_fin  = w_done_q  | w_ready;

    // NOTE: every signal assigned here gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        gnt_o     = 1'b0;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        ar_valid  = 1'b0;
        b_ready   = 1'b0;
        r_ready   = 1'b0;
        rvalid_o  = 1'b0;

        case (state_q)
            IDLE: begin
                gnt_o = req_i & ~rst_i;
                if (req_i) begin
                    state_d = we_i ? SEND_AW_W : SEND_AR;
                end
            end
            SEND_AW_W: begin
                aw_valid = ~aw_done_q;
                w_valid  = ~w_done_q;
                if (aw_fin && w_fin) begin
                    state_d   = WAIT_B;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_fin;
                    w_done_d  = w_fin;
                end
            end
            SEND_AR: begin
                ar_valid = 1'b1;
                if (ar_ready) begin
                    state_d = WAIT_R;
                end
            end
            WAIT_B: begin
                b_ready = 1'b1;
                if (b_valid) begin
                    state_d = RESP;
                end
            end
            WAIT_R: begin
                r_ready = 1'b1;
                if (r_valid) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rvalid_o = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            if (state_q == WAIT_B && b_valid) begin
                err_q <= b_resp[1];
            end
            if (state_q == WAIT_R && r_valid) begin
                rdata_q <= r_data;
                err_q   <= r_resp[1] | ~r_last;
            end
        end
    end

    // NOTE: the request payload is left unreset; it is only observed while a valid is high,
    // and every valid is low after reset.
    always_ff @(posedge clk_i) begin
        if (gnt_o) begin
            addr_q  <= {addr_i[AXI_ADDR_WIDTH-1:LOG_NR_BYTES], {LOG_NR_BYTES{1'b0}}};
            be_q    <= be_i;
            wdata_q <= wdata_i;
        end
    end

    assign rdata_o   = rdata_q;
    assign err_o     = rvalid_o & err_q;

    assign aw_id     = TXN_ID;
    assign aw_addr   = addr_q;
    assign aw_len    = 8'd0;
    assign aw_size   = AX_SIZE;
    assign aw_burst  = BURST_INCR;
    assign aw_lock   = 1'b0;
    assign aw_cache  = 4'd0;
    assign aw_prot   = 3'd0;
    assign aw_qos    = 4'd0;
    assign aw_region = 4'd0;
    assign aw_user   = '0;

    assign w_data    = wdata_q;
    assign w_strb    = be_q;
    assign w_last    = 1'b1;
    assign w_user    = '0;

    assign ar_id     = TXN_ID;
    assign ar_addr   = addr_q;
    assign ar_len    = 8'd0;
    assign ar_size   = AX_SIZE;
    assign ar_burst  = BURST_INCR;
    assign ar_lock   = 1'b0;
    assign ar_cache  = 4'd0;
    assign ar_prot   = 3'd0;
    assign ar_qos    = 4'd0;
    assign ar_region = 4'd0;
    assign ar_user   = '0;

endmodule

// File: tb/tb_mem2axi.sv
// Directed bench for mem2axi: a table of single transactions against a delay-configurable AXI
// slave model, plus hand-written back-to-back and mid-transaction-reset sequences.
module tb_mem2axi;

    logic        clk_i;
    logic        rst_i;
    logic        req_i;
    logic        gnt_o;
    logic        we_i;
    logic [63:0] addr_i;
    logic [7:0]  be_i;
    logic [63:0] wdata_i;
    logic        rvalid_o;
    logic [63:0] rdata_o;
    logic        err_o;

    logic [9:0]  aw_id;
    logic [63:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        aw_lock;
    logic [3:0]  aw_cache;
    logic [2:0]  aw_prot;
    logic [3:0]  aw_qos;
    logic [3:0]  aw_region;
    logic [9:0]  aw_user;
    logic        aw_valid;
    logic        aw_ready;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_last;
    logic [9:0]  w_user;
    logic        w_valid;
    logic        w_ready;
    logic [9:0]  b_id;
    logic [1:0]  b_resp;
    logic [9:0]  b_user;
    logic        b_valid;
    logic        b_ready;
    logic [9:0]  ar_id;
    logic [63:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        ar_lock;
    logic [3:0]  ar_cache;
    logic [2:0]  ar_prot;
    logic [3:0]  ar_qos;
    logic [3:0]  ar_region;
    logic [9:0]  ar_user;
    logic        ar_valid;
    logic        ar_ready;
    logic [9:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [9:0]  r_user;
    logic        r_valid;
    logic        r_ready;

    mem2axi dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .gnt_o     (gnt_o),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .be_i      (be_i),
        .wdata_i   (wdata_i),
        .rvalid_o  (rvalid_o),
        .rdata_o   (rdata_o),
        .err_o     (err_o),
        .aw_id     (aw_id),
        .aw_addr   (aw_addr),
        .aw_len    (aw_len),
        .aw_size   (aw_size),
        .aw_burst  (aw_burst),
        .aw_lock   (aw_lock),
        .aw_cache  (aw_cache),
        .aw_prot   (aw_prot),
        .aw_qos    (aw_qos),
        .aw_region (aw_region),
        .aw_user   (aw_user),
        .aw_valid  (aw_valid),
        .aw_ready  (aw_ready),
        .w_data    (w_data),
        .w_strb    (w_strb),
        .w_last    (w_last),
        .w_user    (w_user),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .b_id      (b_id),
        .b_resp    (b_resp),
        .b_user    (b_user),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .ar_id     (ar_id),
        .ar_addr   (ar_addr),
        .ar_len    (ar_len),
        .ar_size   (ar_size),
        .ar_burst  (ar_burst),
        .ar_lock   (ar_lock),
        .ar_cache  (ar_cache),
        .ar_prot   (ar_prot),
        .ar_qos    (ar_qos),
        .ar_region (ar_region),
        .ar_user   (ar_user),
        .ar_valid  (ar_valid),
        .ar_ready  (ar_ready),
        .r_id      (r_id),
        .r_data    (r_data),
        .r_resp    (r_resp),
        .r_last    (r_last),
        .r_user    (r_user),
        .r_valid   (r_valid),
        .r_ready   (r_ready)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Expected AX payload: aligned address, single beat of 8 bytes, INCR, ID 0, all side fields 0.
    function automatic logic [112:0] exp_ax(input logic [63:0] addr);
        return {addr, 8'd0, 3'd3, 2'b01, 10'd0, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 10'd0};
    endfunction

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
        int          a_dly;     // cycles before aw_ready/ar_ready rises
        int          w_dly;     // cycles before w_ready rises
        int          r_dly;     // extra cycles before b_valid/r_valid
        logic [1:0]  resp;
        logic        last;
        logic [63:0] rdata;
        logic        exp_err;
    } vec_t;

    task automatic slave_idle();
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        ar_ready = 1'b0;
        b_valid  = 1'b0;
        r_valid  = 1'b0;
        b_resp   = 2'b00;
        r_resp   = 2'b00;
        r_last   = 1'b1;
        r_data   = '0;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        logic [63:0] exp_addr;
        bit          a_seen, w_seen, rsp_seen;
        int          rsp_start, rsp_cyc;
        logic        e_aw, e_w, e_ar, e_b, e_r, e_rv;
        exp_addr  = {v.addr[63:3], 3'b000};
        a_seen    = 1'b0;
        w_seen    = 1'b0;
        rsp_seen  = 1'b0;
        rsp_start = -1;
        rsp_cyc   = -1;

        @(negedge clk_i);
        req_i   = 1'b1;
        we_i    = v.we;
        addr_i  = v.addr;
        be_i    = v.be;
        wdata_i = v.wdata;
        #1 check({tag, " gnt"}, 128'(gnt_o), 128'(1'b1));

        @(negedge clk_i);
        req_i   = 1'b0;
        addr_i  = '1;
        be_i    = '0;
        wdata_i = 64'h5A5A_5A5A_5A5A_5A5A;
        for (int n = 0; n < 40; n++) begin
            aw_ready = v.we && n >= v.a_dly;
            ar_ready = !v.we && n >= v.a_dly;
            w_ready  = v.we && n >= v.w_dly;
            b_valid  = v.we && rsp_start >= 0 && n >= rsp_start && !rsp_seen;
            r_valid  = !v.we && rsp_start >= 0 && n >= rsp_start && !rsp_seen;
            b_resp   = v.resp;
            r_resp   = v.resp;
            r_last   = v.last;
            r_data   = v.rdata;
            #1;
            e_aw = v.we && !a_seen;
            e_w  = v.we && !w_seen;
            e_ar = !v.we && !a_seen;
            e_b  = v.we && a_seen && w_seen && !rsp_seen;
            e_r  = !v.we && a_seen && !rsp_seen;
            e_rv = rsp_seen && n == rsp_cyc + 1;
            check({tag, " ctl"},
                  128'({gnt_o, aw_valid, w_valid, ar_valid, b_ready, r_ready, rvalid_o, err_o}),
                  128'({1'b0, e_aw, e_w, e_ar, e_b, e_r, e_rv, e_rv & v.exp_err}));
            if (e_aw) begin
                check({tag, " aw"}, 128'({aw_addr, aw_len, aw_size, aw_burst, aw_id, aw_lock,
                      aw_cache, aw_prot, aw_qos, aw_region, aw_user}), 128'(exp_ax(exp_addr)));
            end
            if (e_w) begin
                check({tag, " w"}, 128'({w_data, w_strb, w_last, w_user}),
                      128'({v.wdata, v.be, 1'b1, 10'd0}));
            end
            if (e_ar) begin
                check({tag, " ar"}, 128'({ar_addr, ar_len, ar_size, ar_burst, ar_id, ar_lock,
                      ar_cache, ar_prot, ar_qos, ar_region, ar_user}), 128'(exp_ax(exp_addr)));
            end
            if (e_rv && !v.we) begin
                check({tag, " rdata"}, 128'(rdata_o), 128'(v.rdata));
            end
            if ((e_aw && aw_ready) || (e_ar && ar_ready)) a_seen = 1'b1;
            if (e_w && w_ready) w_seen = 1'b1;
            if (rsp_start < 0 && a_seen && (w_seen || !v.we)) rsp_start = n + 1 + v.r_dly;
            if ((e_b && b_valid) || (e_r && r_valid)) begin
                rsp_seen = 1'b1;
                rsp_cyc  = n;
            end
            if (rsp_seen && n == rsp_cyc + 2) break;
            @(negedge clk_i);
        end
        slave_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b0, 64'h1007, 8'h00, 64'h0, 0, 0, 0, 2'b00, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};
        vecs[1] = '{1'b1, 64'h2000, 8'h0F, 64'h1122_3344_5566_7788, 0, 0, 0, 2'b00, 1'b1, 64'h0, 1'b0};
        vecs[2] = '{1'b1, 64'h300F, 8'hF0, 64'hA1A2_A3A4_A5A6_A7A8, 3, 0, 1, 2'b00, 1'b1, 64'h0, 1'b0};
        vecs[3] = '{1'b0, 64'h4010, 8'h00, 64'h0, 1, 0, 0, 2'b10, 1'b1, 64'h0BAD_0BAD_0BAD_0BAD, 1'b1};
        vecs[4] = '{1'b1, 64'h5004, 8'hFF, 64'hFFFF_0000_FFFF_0000, 0, 0, 2, 2'b11, 1'b1, 64'h0, 1'b1};
        vecs[5] = '{1'b0, 64'h6000, 8'h00, 64'h0, 0, 0, 1, 2'b00, 1'b0, 64'h1111_2222_3333_4444, 1'b1};
        vecs[6] = '{1'b1, 64'h7001, 8'h81, 64'h0102_0304_0506_0708, 0, 2, 0, 2'b00, 1'b1, 64'h0, 1'b0};
        vecs[7] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'h0, 2, 0, 3, 2'b00, 1'b1,
                    64'h8765_4321_0FED_CBA9, 1'b0};
        vecs[8] = '{1'b1, 64'h9008, 8'h3C, 64'hC0DE_C0DE_C0DE_C0DE, 0, 0, 0, 2'b01, 1'b1, 64'h0, 1'b0};

        rst_i   = 1'b1;
        req_i   = 1'b0;
        we_i    = 1'b0;
        addr_i  = '0;
        be_i    = '0;
        wdata_i = '0;
        b_id    = '0;
        b_user  = '0;
        r_id    = '0;
        r_user  = '0;
        slave_idle();

        repeat (3) @(negedge clk_i);
        #1;
        check("reset ctl", 128'({gnt_o, aw_valid, w_valid, ar_valid, b_ready, r_ready, rvalid_o, err_o}),
              128'(8'h00));
        check("reset rdata", 128'(rdata_o), 128'(64'h0));
        rst_i = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back reads with req_i held high: grants only every fourth cycle.
        @(negedge clk_i);
        we_i     = 1'b0;
        be_i     = '0;
        ar_ready = 1'b1;
        r_valid  = 1'b1;
        r_resp   = 2'b00;
        r_last   = 1'b1;
        for (int c = 0; c < 14; c++) begin
            req_i  = (c <= 8);
            addr_i = 64'h8005 + 64'(c / 4) * 64'd8;
            r_data = 64'hA0 + 64'(c / 4);
            #1;
            check($sformatf("b2b gnt c%0d", c), 128'(gnt_o), 128'((c % 4 == 0) && c < 12));
            check($sformatf("b2b rvalid c%0d", c), 128'(rvalid_o), 128'((c % 4 == 3) && c < 12));
            if (c % 4 == 1 && c < 12) begin
                check($sformatf("b2b ar_addr c%0d", c), 128'({ar_valid, ar_addr}),
                      128'({1'b1, 64'h8000 + 64'(c / 4) * 64'd8}));
            end
            if (c % 4 == 3 && c < 12) begin
                check($sformatf("b2b rdata c%0d", c), 128'(rdata_o), 128'(64'hA0 + 64'(c / 4)));
            end
            @(negedge clk_i);
        end
        req_i = 1'b0;
        slave_idle();

        // Reset while waiting for read data drops everything; stray read data afterwards is ignored.
        @(negedge clk_i);
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = 64'h4000;
        #1 check("rst gnt", 128'(gnt_o), 128'(1'b1));
        @(negedge clk_i);
        req_i    = 1'b0;
        ar_ready = 1'b1;
        #1 check("rst ar_valid", 128'(ar_valid), 128'(1'b1));
        @(negedge clk_i);
        ar_ready = 1'b0;
        #1 check("rst in WAIT_R", 128'({ar_valid, r_ready}), 128'(2'b01));
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1 check("rst after", 128'({gnt_o, aw_valid, w_valid, ar_valid, b_ready, r_ready, rvalid_o, err_o}),
                 128'(8'h00));
        r_valid = 1'b1;
        r_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            #1;
            check("rst stray r", 128'({r_ready, rvalid_o, err_o}), 128'(3'b000));
            check("rst rdata", 128'(rdata_o), 128'(64'h0));
        end
        slave_idle();
        run_txn('{1'b0, 64'h5000, 8'h00, 64'h0, 0, 0, 0, 2'b00, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0},
                "post-rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
